// File: rtl/sprite_blitter_pkg.sv
// rtl/sprite_blitter_pkg.sv - shared screen defaults, RGB565 colours, colour key and FSM encoding
package sprite_blitter_pkg;

  localparam int LCD_WIDTH_DEFAULT  = 240;
  localparam int LCD_HEIGHT_DEFAULT = 320;

  localparam logic [15:0] RGB565_BLACK = 16'h0000;
  localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB565_RED   = 16'hF800;
  localparam logic [15:0] RGB565_GREEN = 16'h07E0;
  localparam logic [15:0] RGB565_BLUE  = 16'h001F;

  localparam logic [15:0] TRANSPARENT_KEY = 16'h0001;

  typedef enum logic [3:0] {
    ST_ARM,
    ST_IDLE,
    ST_HDR_W,
    ST_HDR_H,
    ST_SETUP,
    ST_FETCH,
    ST_EMIT,
    ST_WAIT,
    ST_NEXT,
    ST_DONE
  } blit_state_e;

endpackage

// File: rtl/sprite_blitter_blit_addr_gen.sv
// rtl/sprite_blitter_blit_addr_gen.sv - row/column walk with mirroring and ROM pixel address generation
module blit_addr_gen #(
  parameter int X_W    = 8,
  parameter int Y_W    = 9,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base,
  input  logic              flip_h,
  input  logic              flip_v,
  input  logic [X_W-1:0]    width,
  input  logic [Y_W-1:0]    height,
  output logic [X_W-1:0]    col,
  output logic [Y_W-1:0]    row,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam int PW = X_W + Y_W;

  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] step;
  logic [PW-1:0]     span;
  logic [X_W-1:0]    col_last;
  logic [Y_W-1:0]    row_last;
  logic [X_W-1:0]    col_sel;

  always_comb begin
    col_last = width - X_W'(1);
    row_last = height - Y_W'(1);
    // offset of the bottom source row, only needed when starting a vertically mirrored job
    span     = PW'(row_last) * PW'(width);
    step     = ADDR_W'(width);
    col_sel  = flip_h ? (col_last - col) : col;
    addr     = row_base + ADDR_W'(col_sel);
    last     = (col == col_last) && (row == row_last);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col      <= '0;
      row      <= '0;
      row_base <= '0;
    end else if (start) begin
      col      <= '0;
      row      <= '0;
      row_base <= base + ADDR_W'(2) + (flip_v ? ADDR_W'(span) : '0);
    end else if (advance) begin
      if (col == col_last) begin
        col      <= '0;
        row      <= row + Y_W'(1);
        row_base <= flip_v ? (row_base - step) : (row_base + step);
      end else begin
        col <= col + X_W'(1);
      end
    end
  end

endmodule

// File: rtl/sprite_blitter.sv
// rtl/sprite_blitter.sv - sprite ROM to LCD pixel-port copy engine with flip, colour key and clipping
module sprite_blitter
  import sprite_blitter_pkg::*;
#(
  parameter int          LCD_WIDTH   = LCD_WIDTH_DEFAULT,
  parameter int          LCD_HEIGHT  = LCD_HEIGHT_DEFAULT,
  parameter int          X_W         = 8,
  parameter int          Y_W         = 9,
  parameter int          ADDR_W      = 16,
  parameter int          ROM_LATENCY = 2,
  parameter logic [15:0] TRANSPARENT = TRANSPARENT_KEY
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [X_W-1:0]    xOrigin,
  input  logic [Y_W-1:0]    yOrigin,
  input  logic [ADDR_W-1:0] spriteBase,
  input  logic              flipH,
  input  logic              flipV,
  input  logic              draw,
  output logic              ready,
  output logic              done,
  output logic [ADDR_W-1:0] romAddr,
  input  logic [15:0]       romData,
  output logic [X_W-1:0]    xAddr,
  output logic [Y_W-1:0]    yAddr,
  output logic [15:0]       pixelData,
  output logic              pixelWrite,
  input  logic              pixelReady,
  output logic [X_W-1:0]    imgWidth,
  output logic [Y_W-1:0]    imgHeight
);

  localparam int LW = $clog2(ROM_LATENCY + 1) + 1;
  localparam logic [LW-1:0] LAT_HDR = LW'(ROM_LATENCY);
  localparam logic [LW-1:0] LAT_PIX = LW'(ROM_LATENCY - 1);

  blit_state_e       state, state_next;
  logic [LW-1:0]     lat_cnt;
  logic [X_W-1:0]    x_org;
  logic [Y_W-1:0]    y_org;
  logic [ADDR_W-1:0] base_q;
  logic              flip_h_q, flip_v_q;
  logic [X_W-1:0]    col;
  logic [Y_W-1:0]    row;
  logic [ADDR_W-1:0] pix_addr;
  logic              last;
  logic [X_W:0]      sx;
  logic [Y_W:0]      sy;
  logic              skip;

  blit_addr_gen #(.X_W(X_W), .Y_W(Y_W), .ADDR_W(ADDR_W)) u_addr_gen (
    .clock   (clock),
    .reset   (reset),
    .start   (state == ST_SETUP),
    .advance (state == ST_NEXT),
    .base    (base_q),
    .flip_h  (flip_h_q),
    .flip_v  (flip_v_q),
    .width   (imgWidth),
    .height  (imgHeight),
    .col     (col),
    .row     (row),
    .addr    (pix_addr),
    .last    (last)
  );

  // screen coordinates carry one extra bit so sprites hanging off the edge clip instead of wrapping
  always_comb begin
    sx   = {1'b0, x_org} + {1'b0, col};
    sy   = {1'b0, y_org} + {1'b0, row};
    skip = (romData == TRANSPARENT) || (sx >= (X_W+1)'(LCD_WIDTH)) || (sy >= (Y_W+1)'(LCD_HEIGHT));
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    done       = 1'b0;
    romAddr    = '0;
    case (state)
      ST_ARM:   if (!draw) state_next = ST_IDLE;
      ST_IDLE: begin
        ready = 1'b1;
        if (draw) state_next = ST_HDR_W;
      end
      ST_HDR_W: begin
        romAddr = base_q;
        if (lat_cnt == LAT_HDR) state_next = ST_HDR_H;
      end
      ST_HDR_H: begin
        romAddr = base_q + ADDR_W'(1);
        if (lat_cnt == LAT_HDR)
          state_next = (imgWidth == '0 || romData[Y_W-1:0] == '0) ? ST_DONE : ST_SETUP;
      end
      ST_SETUP: state_next = ST_FETCH;
      ST_FETCH: begin
        romAddr = pix_addr;
        if (lat_cnt == LAT_PIX) state_next = ST_EMIT;
      end
      ST_EMIT: begin
        romAddr    = pix_addr;
        state_next = skip ? ST_NEXT : ST_WAIT;
      end
      ST_WAIT: begin
        romAddr = pix_addr;
        if (pixelReady) state_next = ST_NEXT;
      end
      ST_NEXT: begin
        romAddr    = pix_addr;
        state_next = last ? ST_DONE : ST_FETCH;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_ARM;
      end
      default: state_next = ST_ARM;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_ARM;
      lat_cnt    <= '0;
      x_org      <= '0;
      y_org      <= '0;
      base_q     <= '0;
      flip_h_q   <= 1'b0;
      flip_v_q   <= 1'b0;
      imgWidth   <= '0;
      imgHeight  <= '0;
      xAddr      <= '0;
      yAddr      <= '0;
      pixelData  <= '0;
      pixelWrite <= 1'b0;
    end else begin
      state   <= state_next;
      lat_cnt <= (state_next != state) ? '0 : lat_cnt + LW'(1);
      if (state == ST_IDLE && draw) begin
        x_org    <= xOrigin;
        y_org    <= yOrigin;
        base_q   <= spriteBase;
        flip_h_q <= flipH;
        flip_v_q <= flipV;
      end
      if (state == ST_HDR_W && lat_cnt == LAT_HDR) imgWidth <= romData[X_W-1:0];
      if (state == ST_HDR_H && lat_cnt == LAT_HDR) imgHeight <= romData[Y_W-1:0];
      if (state == ST_EMIT && !skip) begin
        xAddr      <= sx[X_W-1:0];
        yAddr      <= sy[Y_W-1:0];
        pixelData  <= romData;
        pixelWrite <= 1'b1;
      end
      if (state == ST_WAIT && pixelReady) pixelWrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_blitter.sv
// tb/tb_sprite_blitter.sv - scoreboard bench for sprite_blitter with a behavioural sprite model
module tb_sprite_blitter;
  import sprite_blitter_pkg::*;

  localparam int LAT = 2;
  localparam logic [15:0] KEY = 16'h0001;

  logic        clock, reset;
  logic [7:0]  xOrigin;
  logic [8:0]  yOrigin;
  logic [15:0] spriteBase;
  logic        flipH, flipV, draw;
  logic        ready, done;
  logic [15:0] romAddr, romData;
  logic [7:0]  xAddr;
  logic [8:0]  yAddr;
  logic [15:0] pixelData;
  logic        pixelWrite, pixelReady;
  logic [7:0]  imgWidth;
  logic [8:0]  imgHeight;

  sprite_blitter #(
    .LCD_WIDTH(240), .LCD_HEIGHT(320), .X_W(8), .Y_W(9), .ADDR_W(16),
    .ROM_LATENCY(LAT), .TRANSPARENT(KEY)
  ) dut (
    .clock(clock), .reset(reset), .xOrigin(xOrigin), .yOrigin(yOrigin),
    .spriteBase(spriteBase), .flipH(flipH), .flipV(flipV), .draw(draw),
    .ready(ready), .done(done), .romAddr(romAddr), .romData(romData),
    .xAddr(xAddr), .yAddr(yAddr), .pixelData(pixelData), .pixelWrite(pixelWrite),
    .pixelReady(pixelReady), .imgWidth(imgWidth), .imgHeight(imgHeight)
  );

  typedef struct {
    bit          is_done;
    int          x;
    int          y;
    logic [15:0] d;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] rom [0:65535];
  logic [15:0] rom_pipe [0:LAT-1];
  int vectors = 0;
  int miscompares = 0;
  int hs_count = 0;
  int stall_cnt = 0;
  int exp_w, exp_h;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ROM with a fixed read latency, as seen by the blitter
  always @(posedge clock) begin
    rom_pipe[0] <= rom[romAddr];
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign romData = rom_pipe[LAT-1];

  initial begin
    pixelReady = 0;
    forever begin
      @(posedge clock);
      #1;
      if (stall_cnt > 0) begin
        pixelReady = 0;
        stall_cnt--;
      end else begin
        pixelReady = ($urandom_range(0, 3) != 0);
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // monitor: pops expected writes/done markers as the DUT presents them
  initial begin
    bit          pend, prev_done;
    logic [7:0]  px;
    logic [8:0]  py;
    logic [15:0] pd;
    exp_t        e;
    pend = 0;
    prev_done = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        pend = 0;
        prev_done = 0;
        continue;
      end
      if (pend)
        chk("hold_stable", 64'({pixelWrite, xAddr, yAddr, pixelData}), 64'({1'b1, px, py, pd}));
      if (prev_done) chk("done_one_cycle", 64'(done), 64'(0));
      pend = pixelWrite && !pixelReady;
      px = xAddr;
      py = yAddr;
      pd = pixelData;
      prev_done = done;
      if (pixelWrite && pixelReady) begin
        hs_count++;
        if (sb.size() == 0) begin
          chk("unexpected_write", 64'({xAddr, yAddr, pixelData}), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("write_not_done", 64'(e.is_done), 64'(0));
          if (!e.is_done)
            chk("write_xyd", 64'({xAddr, yAddr, pixelData}), 64'({8'(e.x), 9'(e.y), e.d}));
        end
      end
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'(0));
        end else begin
          e = sb.pop_front();
          chk("done_order", 64'(e.is_done), 64'(1));
        end
      end
    end
  end

  // reference: walk the output raster and pick the source pixel by mirroring rules
  task automatic push_expected(input int x, input int y, input logic [15:0] b, input bit fh, input bit fv);
    logic [15:0] b1, ai;
    int          w, h, sr, sc;
    exp_t        e;
    b1 = b + 16'd1;
    w = int'(rom[b][7:0]);
    h = int'(rom[b1][8:0]);
    exp_w = w;
    exp_h = h;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        sr = fv ? h - 1 - r : r;
        sc = fh ? w - 1 - c : c;
        ai = 16'(int'(b) + 2 + sr * w + sc);
        if (rom[ai] != KEY && x + c < 240 && y + r < 320) begin
          e.is_done = 0;
          e.x = x + c;
          e.y = y + r;
          e.d = rom[ai];
          sb.push_back(e);
        end
      end
    end
    e.is_done = 1;
    e.x = 0;
    e.y = 0;
    e.d = 0;
    sb.push_back(e);
  endtask

  task automatic fill_sprite(input logic [15:0] b, input int w, input int h, input bit with_key);
    logic [15:0] a;
    rom[b] = {8'($urandom), 8'(w)};
    a = b + 16'd1;
    rom[a] = {7'($urandom), 9'(h)};
    for (int i = 0; i < w * h; i++) begin
      a = 16'(int'(b) + 2 + i);
      rom[a] = (with_key && $urandom_range(0, 4) == 0) ? KEY : 16'($urandom);
      if (!with_key && rom[a] == KEY) rom[a] = RGB565_BLACK;
    end
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 300) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (!ready) chk("ready_timeout", 64'(ready), 64'(1));
  endtask

  task automatic issue(input int x, input int y, input logic [15:0] b, input bit fh, input bit fv);
    push_expected(x, y, b, fh, fv);
    wait_ready();
    xOrigin = 8'(x);
    yOrigin = 9'(y);
    spriteBase = b;
    flipH = fh;
    flipV = fv;
    draw = 1;
    @(posedge clock);
    #1;
    draw = 0;
    xOrigin = 8'($urandom);
    yOrigin = 9'($urandom);
    spriteBase = 16'($urandom);
    flipH = 1'($urandom);
    flipV = 1'($urandom);
  endtask

  task automatic finish_job();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(posedge clock);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      chk("job_timeout", 64'(sb.size()), 64'(0));
      sb.delete();
    end
    chk("img_width", 64'(imgWidth), 64'(exp_w));
    chk("img_height", 64'(imgHeight), 64'(exp_h));
  endtask

  task automatic run_job(input int x, input int y, input logic [15:0] b, input bit fh, input bit fv);
    issue(x, y, b, fh, fv);
    finish_job();
  endtask

  initial begin
    int hs0, n, x, y, w, h;
    logic [15:0] b;
    for (int i = 0; i < 65536; i++) rom[i] = 16'h0000;
    reset = 1;
    draw = 0;
    xOrigin = 0;
    yOrigin = 0;
    spriteBase = 0;
    flipH = 0;
    flipV = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_ctrl", 64'({ready, done, pixelWrite, romAddr}), 64'(0));
    chk("reset_pix", 64'({xAddr, yAddr, pixelData, imgWidth, imgHeight}), 64'(0));
    reset = 0;

    rom[16'h10] = 16'd2;
    rom[16'h11] = 16'd2;
    rom[16'h12] = RGB565_RED;
    rom[16'h13] = RGB565_GREEN;
    rom[16'h14] = RGB565_BLUE;
    rom[16'h15] = RGB565_WHITE;
    run_job(10, 20, 16'h10, 0, 0);
    run_job(10, 20, 16'h10, 1, 1);

    rom[16'h40] = 16'd3;
    rom[16'h41] = 16'd1;
    rom[16'h42] = RGB565_RED;
    rom[16'h43] = KEY;
    rom[16'h44] = RGB565_BLUE;
    hs0 = hs_count;
    run_job(10, 20, 16'h40, 0, 0);
    chk("key_write_count", 64'(hs_count - hs0), 64'(2));

    fill_sprite(16'h80, 4, 4, 0);
    hs0 = hs_count;
    run_job(238, 318, 16'h80, 0, 0);
    chk("clip_write_count", 64'(hs_count - hs0), 64'(4));

    stall_cnt = 60;
    run_job(10, 20, 16'h10, 0, 0);

    rom[16'h300] = 16'd0;
    rom[16'h301] = 16'd5;
    hs0 = hs_count;
    run_job(5, 5, 16'h300, 0, 0);
    rom[16'h310] = 16'd3;
    rom[16'h311] = 16'd0;
    run_job(5, 5, 16'h310, 1, 0);
    chk("empty_write_count", 64'(hs_count - hs0), 64'(0));

    fill_sprite(16'h200, 6, 6, 0);
    hs0 = hs_count;
    issue(0, 0, 16'h200, 0, 0);
    n = 0;
    while (hs_count < hs0 + 8 && n < 2000) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk("pre_reset_progress", 64'(hs_count >= hs0 + 8), 64'(1));
    draw = 1;
    reset = 1;
    sb.delete();
    @(negedge clock);
    chk("midjob_reset_ctrl", 64'({ready, done, pixelWrite, romAddr}), 64'(0));
    chk("midjob_reset_pix", 64'({xAddr, yAddr, pixelData, imgWidth, imgHeight}), 64'(0));
    repeat (2) @(posedge clock);
    #1;
    reset = 0;
    repeat (20) @(posedge clock);
    #1;
    chk("held_draw_no_job", 64'({ready, pixelWrite, romAddr}), 64'(0));
    draw = 0;

    for (int j = 0; j < 30; j++) begin
      w = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
      h = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 7);
      b = ($urandom_range(0, 3) == 0) ? 16'(32'hFFFA + $urandom_range(0, 5)) : 16'($urandom);
      x = $urandom_range(0, 1) ? $urandom_range(0, 255) : $urandom_range(228, 255);
      y = $urandom_range(0, 1) ? $urandom_range(0, 330) : $urandom_range(308, 511);
      fill_sprite(b, w, h, 1);
      run_job(x, y, b, 1'($urandom), 1'($urandom));
    end

    repeat (10) @(posedge clock);
    #1;
    chk("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
